// File: rtl/coherence_bus_arbiter.sv
// Round-robin arbiter for a snooping MOESI coherence bus: grants one cache, broadcasts its op,
// gathers snoop replies, picks the data source and sequences memory until completion.
module coherence_bus_arbiter #(
   parameter int N_CACHES = 4,
   parameter int IDX_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_CACHES-1:0]     req,
   input  logic [2*N_CACHES-1:0]   req_op,
   input  logic [3*N_CACHES-1:0]   snoop_state,
   input  logic [N_CACHES-1:0]     snoop_abort,
   input  logic [N_CACHES-1:0]     snoop_shared,
   input  logic                    mem_ready,
   output logic [N_CACHES-1:0]     grant,
   output logic                    bus_read,
   output logic                    bus_rwitm,
   output logic                    bus_invalidate,
   output logic [2:0]              bus_from_state,
   output logic                    mem_req,
   output logic                    done,
   output logic                    done_shared,
   output logic                    protocol_error
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BCAST,
      S_XFER,
      S_MEM_WAIT,
      S_DONE
   } state_t;

   localparam logic [2:0] FROM_M   = 3'b001;
   localparam logic [2:0] FROM_O   = 3'b011;
   localparam logic [2:0] FROM_E   = 3'b100;
   localparam logic [2:0] FROM_MEM = 3'b101;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_RWITM = 2'b10;
   localparam logic [1:0] OP_INV   = 2'b11;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [1:0]          op_q, op_d;
   logic [N_CACHES-1:0] grant_q, grant_d;
   logic                any_shared_q, any_shared_d;
   logic [2:0]          from_q, from_d;
   logic                perr_q, perr_d;

   logic [N_CACHES-1:0] elig;
   logic [IDX_W:0]      scan_idx;
   logic                found;
   logic [IDX_W-1:0]    pick;
   logic [1:0]          pick_op;

   logic                snp_abort, snp_shared, has_m, has_o, has_e;
   logic [3:0]          dirty_cnt;
   logic [2:0]          snp_st;
   logic [2:0]          snp_from;

   // Scan rr_ptr, rr_ptr+1, ... modulo N_CACHES for the first eligible requester.
   always_comb begin
      elig     = '0;
      scan_idx = '0;
      found    = 1'b0;
      pick     = '0;
      pick_op  = 2'b00;
      for (int i = 0; i < N_CACHES; i++) begin
         elig[i] = req[i] & (req_op[2*i +: 2] != 2'b00);
      end
      for (int k = 0; k < N_CACHES; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (scan_idx >= (IDX_W+1)'(N_CACHES)) begin
            scan_idx = scan_idx - (IDX_W+1)'(N_CACHES);
         end
         if (!found && elig[scan_idx[IDX_W-1:0]]) begin
            found = 1'b1;
            pick  = scan_idx[IDX_W-1:0];
         end
      end
      for (int i = 0; i < N_CACHES; i++) begin
         if (IDX_W'(i) == pick) pick_op = req_op[2*i +: 2];
      end
   end

   // The owner's own snoop reply describes the line it is asking for, so it is excluded.
   always_comb begin
      snp_abort  = 1'b0;
      snp_shared = 1'b0;
      has_m      = 1'b0;
      has_o      = 1'b0;
      has_e      = 1'b0;
      dirty_cnt  = '0;
      snp_st     = '0;
      for (int i = 0; i < N_CACHES; i++) begin
         if (IDX_W'(i) != owner_q) begin
            snp_st     = snoop_state[3*i +: 3];
            snp_abort  = snp_abort | snoop_abort[i];
            snp_shared = snp_shared | snoop_shared[i] | (snp_st != 3'b000);
            if (snp_st == FROM_M) has_m = 1'b1;
            if (snp_st == FROM_O) has_o = 1'b1;
            if (snp_st == FROM_E) has_e = 1'b1;
            if (snp_st == FROM_M || snp_st == FROM_O || snp_st == FROM_E) begin
               dirty_cnt = dirty_cnt + 4'd1;
            end
         end
      end
      snp_from = has_m ? FROM_M : has_o ? FROM_O : has_e ? FROM_E : FROM_MEM;
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      op_d         = op_q;
      grant_d      = grant_q;
      any_shared_d = any_shared_q;
      from_d       = from_q;
      perr_d       = perr_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               owner_d = pick;
               op_d    = pick_op;
               grant_d = N_CACHES'(1) << pick;
               state_d = S_BCAST;
            end
         end
         S_BCAST: begin
            any_shared_d = snp_shared;
            from_d       = snp_from;
            if (dirty_cnt > 4'd1) perr_d = 1'b1;
            if (op_q == OP_INV)  state_d = S_DONE;
            else if (snp_abort)  state_d = S_XFER;
            else                 state_d = S_MEM_WAIT;
         end
         S_XFER: state_d = S_DONE;
         S_MEM_WAIT: begin
            if (mem_ready) state_d = S_DONE;
         end
         S_DONE: begin
            grant_d  = '0;
            op_d     = 2'b00;
            from_d   = FROM_MEM;
            rr_ptr_d = (owner_q == IDX_W'(N_CACHES-1)) ? '0 : owner_q + IDX_W'(1);
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         op_q         <= 2'b00;
         grant_q      <= '0;
         any_shared_q <= 1'b0;
         from_q       <= FROM_MEM;
         perr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         op_q         <= op_d;
         grant_q      <= grant_d;
         any_shared_q <= any_shared_d;
         from_q       <= from_d;
         perr_q       <= perr_d;
      end
   end

   logic op_active;
   assign op_active      = (state_q == S_BCAST) || (state_q == S_XFER) || (state_q == S_MEM_WAIT);
   assign grant          = grant_q;
   assign bus_read       = op_active && (op_q == OP_READ);
   assign bus_rwitm      = op_active && (op_q == OP_RWITM);
   assign bus_invalidate = op_active && (op_q == OP_INV);
   assign bus_from_state = from_q;
   assign mem_req        = (state_q == S_MEM_WAIT);
   assign done           = (state_q == S_DONE);
   // Only a READ can end up SHARED; ownership requests always finish exclusive.
   assign done_shared    = done && any_shared_q && (op_q == OP_READ);
   assign protocol_error = perr_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Scoreboard bench for coherence_bus_arbiter: directed transactions push expected completions,
// a monitor pops and compares on every done pulse.
module tb_coherence_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [7:0]  req_op;
   logic [11:0] snoop_state;
   logic [3:0]  snoop_abort;
   logic [3:0]  snoop_shared;
   logic        mem_ready;
   logic [3:0]  grant;
   logic        bus_read, bus_rwitm, bus_invalidate;
   logic [2:0]  bus_from_state;
   logic        mem_req, done, done_shared, protocol_error;

   coherence_bus_arbiter #(.N_CACHES(4), .IDX_W(2)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .snoop_state(snoop_state),
      .snoop_abort(snoop_abort), .snoop_shared(snoop_shared), .mem_ready(mem_ready),
      .grant(grant), .bus_read(bus_read), .bus_rwitm(bus_rwitm), .bus_invalidate(bus_invalidate),
      .bus_from_state(bus_from_state), .mem_req(mem_req), .done(done), .done_shared(done_shared),
      .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] grant;
      logic       shared;
      logic [2:0] from;
      int         lat;
      int         memc;
      int         opc;
      logic [1:0] op;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   mem_lat = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] op_line(input logic [1:0] op);
      case (op)
         2'b01:   return 3'b001;
         2'b10:   return 3'b010;
         2'b11:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   // Monitor: measures latency, mem_req and op-line cycles per transaction, checks on done.
   initial begin
      logic [3:0] pg;
      int         start, memc, opc;
      exp_t       e;
      pg = '0; start = 0; memc = 0; opc = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pg = '0; memc = 0; opc = 0;
         end else begin
            if (grant != 4'b0 && pg == 4'b0) begin
               start = cyc; memc = 0; opc = 0;
            end
            if (mem_req) memc++;
            if (sb.size() > 0 && {bus_invalidate, bus_rwitm, bus_read} == op_line(sb[0].op)) opc++;
            if (done) begin
               if (sb.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done: grant=%b with nothing pending", grant);
               end else begin
                  e = sb.pop_front();
                  chk("grant", grant, e.grant);
                  chk("done_shared", done_shared, e.shared);
                  chk("bus_from_state", bus_from_state, e.from);
                  chk("latency", cyc - start + 1, e.lat);
                  chk("mem_req_cycles", memc, e.memc);
                  chk("op_line_cycles", opc, e.opc);
               end
            end
            pg = grant;
         end
      end
   end

   // Memory model: raises mem_ready mem_lat cycles after mem_req first appears.
   initial begin
      int w;
      w = 0;
      mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && rst_n) begin
            mem_ready = (w == mem_lat);
            w++;
         end else begin
            mem_ready = 1'b0;
            w = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [1:0] op);
      req_op[2*i +: 2] = op;
   endtask

   task automatic set_snoop(input int i, input logic [2:0] st, input logic ab, input logic sh);
      snoop_state[3*i +: 3] = st;
      snoop_abort[i]        = ab;
      snoop_shared[i]       = sh;
   endtask

   task automatic clear_snoop();
      snoop_state = '0; snoop_abort = '0; snoop_shared = '0;
   endtask

   task automatic push(input logic [3:0] g, input logic sh, input logic [2:0] from,
                       input int lat, input int memc, input int opc, input logic [1:0] op);
      exp_t e;
      e.grant = g; e.shared = sh; e.from = from; e.lat = lat; e.memc = memc; e.opc = opc; e.op = op;
      sb.push_back(e);
   endtask

   task automatic finish_one();
      logic [3:0] g;
      int n;
      g = '0;
      n = 0;
      while (n < 60) begin
         @(negedge clk);
         if (done) begin
            g = grant;
            break;
         end
         n++;
      end
      if (n >= 60) begin
         checks++; errors++;
         $display("FAIL wait_done: no done within 60 cycles");
      end
      tick();
      req = req & ~g;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_grant"}, grant, 4'b0000);
      chk({tag, "_mem_req"}, mem_req, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_from_state"}, bus_from_state, 3'b101);
      chk({tag, "_op_lines"}, {bus_invalidate, bus_rwitm, bus_read}, 3'b000);
   endtask

   initial begin
      int n;
      rst_n = 1'b0; req = '0; req_op = '0;
      clear_snoop();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("por");
      chk("por_protocol_error", protocol_error, 1'b0);
      chk("por_done_shared", done_shared, 1'b0);
      tick();
      rst_n = 1'b1;

      // Reset in the middle of MEM_WAIT
      mem_lat = 100;
      req[2] = 1'b1; set_op(2, 2'b01);
      n = 0;
      while (n < 20 && !mem_req) begin
         @(negedge clk);
         n++;
      end
      chk("reach_mem_wait", mem_req, 1'b1);
      repeat (2) @(negedge clk);
      tick();
      rst_n = 1'b0; req = '0; req_op = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("midreset");
      tick();
      rst_n = 1'b1;
      mem_lat = 0;

      // After reset the pointer starts at cache 0 again
      push(4'b0001, 1'b0, 3'b101, 3, 1, 2, 2'b01);
      push(4'b1000, 1'b0, 3'b101, 3, 1, 2, 2'b01);
      req = 4'b1001; set_op(0, 2'b01); set_op(3, 2'b01);
      finish_one();
      finish_one();

      // Cache 1 READ, memory after 2 waits; its own snoop reply must be ignored
      mem_lat = 2;
      set_snoop(1, 3'b001, 1'b1, 1'b1);
      push(4'b0010, 1'b0, 3'b101, 5, 3, 4, 2'b01);
      req_op = '0; req[1] = 1'b1; set_op(1, 2'b01);
      finish_one();
      clear_snoop();
      mem_lat = 0;

      // Cache 0 RWITM, cache 2 in M intervenes
      set_snoop(2, 3'b001, 1'b1, 1'b0);
      push(4'b0001, 1'b0, 3'b001, 3, 0, 2, 2'b10);
      req_op = '0; req[0] = 1'b1; set_op(0, 2'b10);
      finish_one();
      clear_snoop();

      // Cache 3 READ, cache 1 in O intervenes and reports shared
      set_snoop(1, 3'b011, 1'b1, 1'b1);
      push(4'b1000, 1'b1, 3'b011, 3, 0, 2, 2'b01);
      req_op = '0; req[3] = 1'b1; set_op(3, 2'b01);
      finish_one();
      clear_snoop();

      // All four READ at once: pointer wrapped to 0, so plain rotation order
      for (int i = 0; i < 4; i++) push(4'b0001 << i, 1'b0, 3'b101, 3, 1, 2, 2'b01);
      req_op = 8'b01_01_01_01; req = 4'b1111;
      for (int i = 0; i < 4; i++) finish_one();

      // Cache 2 INVALIDATE with two sharers
      set_snoop(0, 3'b010, 1'b0, 1'b1);
      set_snoop(1, 3'b010, 1'b0, 1'b1);
      push(4'b0100, 1'b0, 3'b101, 2, 0, 1, 2'b11);
      req_op = '0; req[2] = 1'b1; set_op(2, 2'b11);
      finish_one();
      @(negedge clk);
      chk("protocol_error_clean", protocol_error, 1'b0);
      clear_snoop();

      // Two caches in M during a READ from cache 3
      set_snoop(0, 3'b001, 1'b1, 1'b0);
      set_snoop(1, 3'b001, 1'b1, 1'b0);
      push(4'b1000, 1'b1, 3'b001, 3, 0, 2, 2'b01);
      req_op = '0; req[3] = 1'b1; set_op(3, 2'b01);
      finish_one();
      @(negedge clk);
      chk("protocol_error_set", protocol_error, 1'b1);
      clear_snoop();

      push(4'b0001, 1'b0, 3'b101, 3, 1, 2, 2'b01);
      req_op = '0; req[0] = 1'b1; set_op(0, 2'b01);
      finish_one();
      @(negedge clk);
      chk("protocol_error_sticky", protocol_error, 1'b1);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/coherence_bus_arbiter.md
Name: coherence_bus_arbiter

Overview:
- Shares the single snooping coherence bus among N cache controllers, each running the MOESI FSM.
- Grants the bus round-robin and broadcasts the winner's transaction (READ, RWITM, INVALIDATE) to the other caches.
- Collects their snoop replies and resolves the data source (intervention or memory).
- Sequences memory access and signals completion, including the shared result the requester needs to choose SHARED or EXCLUSIVE.

Parameters:
- N_CACHES, 4, number of requesting cache controllers (2..8).
- IDX_W, 2, width of owner index; must equal clog2(N_CACHES).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req  in  N_CACHES  per-cache bus request; hold until done
- req_op  in  2*N_CACHES  per-cache op, slice i = [2i+1:2i]; 00 none, 01 READ, 10 RWITM, 11 INVALIDATE
- snoop_state  in  3*N_CACHES  per-cache current state of the broadcast line; 000 I, 001 M, 010 S, 011 O, 100 E
- snoop_abort  in  N_CACHES  per-cache intervention reply (abort_mem_access_next)
- snoop_shared  in  N_CACHES  per-cache shared reply
- mem_ready  in  1  memory data valid for the pending access
- grant  out  N_CACHES  one-hot bus ownership
- bus_read, bus_rwitm, bus_invalidate  out  1 each  broadcast op lines
- bus_from_state  out  3  data source; 001 FROM_M, 011 FROM_O, 100 FROM_E, 101 FROM_MEM
- mem_req  out  1  memory access request
- done  out  1  one-cycle completion pulse for the granted cache
- done_shared  out  1  valid with done; another cache holds the line
- protocol_error  out  1  sticky; more than one snooper in M/O/E

Behaviour:
- Reset (rst_n=0 at a clk edge) forces all outputs to 0 except bus_from_state=101. Resets take effect in any state and abort the transaction in flight.
- Reset also sets state=IDLE, rr_ptr=0, owner=0, op register=00.
- States:
  - IDLE: eligible = req[i] & (req_op slice i != 00). If none is eligible, stay. Otherwise select the first eligible index scanning rr_ptr, rr_ptr+1, ... modulo N_CACHES. Latch owner and op, set grant=onehot(owner), go to BCAST.
  - BCAST (exactly 1 cycle): assert the bus op line matching the latched op. Snoop inputs from the owner are masked out. Register the following at the end of the cycle:
    - any_abort = OR of others' snoop_abort
    - any_shared = OR of others' snoop_shared or any other snoop_state != 000
    - bus_from_state: priority M > O > E > MEM among others' snoop_state
  - protocol_error sets if more than one other cache is in M, O or E.
  - Next state from BCAST: INVALIDATE goes to DONE. Otherwise any_abort goes to XFER, else MEM_WAIT.
  - XFER (1 cycle): cache-to-cache transfer; bus op line stays asserted. Next state DONE.
  - MEM_WAIT: mem_req=1 and the op line stays asserted. On the cycle mem_ready=1, go to DONE; mem_req drops the following cycle. No timeout.
  - DONE (1 cycle): done=1. done_shared=any_shared, forced 0 for RWITM and INVALIDATE. Then:
    - grant<=0, op lines<=0, bus_from_state<=101
    - rr_ptr<=(owner+1) mod N_CACHES
    - go to IDLE
- bus_from_state is held stable from the cycle after BCAST through DONE.
- Latency from the IDLE cycle where req is sampled to done:
  - INVALIDATE: 2 cycles
  - intervention: 3 cycles
  - memory: 3 cycles + mem_ready wait
- A cache dropping req or changing req_op mid-transaction is ignored; the latched op completes.
- mem_ready outside MEM_WAIT is ignored.
- Owner wrap: owner N_CACHES-1 sets rr_ptr=0.
- Back-to-back requests: minimum 1 IDLE cycle between transactions.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles mid-MEM_WAIT -> grant=0, mem_req=0, done=0, bus_from_state=101. The next request is granted from cache 0 first.
- Cache 1 READ, all others 000, mem_ready 2 cycles after MEM_WAIT entry:
  - grant=0010, bus_read=1
  - bus_from_state=101
  - mem_req high 3 cycles
  - done with done_shared=0 (EXCLUSIVE case)
- Cache 0 RWITM, cache 2 state 001 with snoop_abort=1 -> XFER path, bus_from_state=001, no mem_req, done at cycle 3, done_shared=0.
- Cache 3 READ, cache 1 in 011 with abort and shared -> bus_from_state=011, done_shared=1. rr_ptr wraps to 0.
- All 4 caches request READ together with memory replies immediate -> grants in order 0001, 0010, 0100, 1000. Each done precedes the next grant.
- Cache 2 INVALIDATE, caches 0 and 1 in 010 -> bus_invalidate=1 for 1 cycle, done 2 cycles after request, done_shared=0. Caches 0 and 1 both in 001 during a READ -> protocol_error=1 and stays 1.
